// File: rtl/ac97_link.sv
// AC'97 AC-link frame engine: drives SYNC/SDATA_OUT with tag, one register write and
// stereo PCM slots, and captures the codec's stereo PCM from SDATA_IN, all on BIT_CLK.
module ac97_link #(
    parameter int FRAME_BITS = 256,
    parameter int SYNC_BITS  = 16,
    parameter int SLOT_BITS  = 20
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 sync,
    output logic                 sdata_out,
    input  logic                 sdata_in,
    input  logic [SLOT_BITS-1:0] tx_left,
    input  logic [SLOT_BITS-1:0] tx_right,
    output logic [SLOT_BITS-1:0] rx_left,
    output logic [SLOT_BITS-1:0] rx_right,
    output logic                 ready,
    output logic                 codec_ready,
    input  logic                 cmd_valid,
    input  logic [6:0]           cmd_addr,
    input  logic [15:0]          cmd_data,
    output logic                 cmd_ready
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int IDX_W = $clog2(SLOT_BITS);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST    = cnt_t'(FRAME_BITS - 1);
    localparam cnt_t TAG_END = cnt_t'(SYNC_BITS - 1);
    localparam cnt_t S1_END  = cnt_t'(SYNC_BITS + 1 * SLOT_BITS - 1);
    localparam cnt_t S2_END  = cnt_t'(SYNC_BITS + 2 * SLOT_BITS - 1);
    localparam cnt_t S3_END  = cnt_t'(SYNC_BITS + 3 * SLOT_BITS - 1);
    localparam cnt_t S4_END  = cnt_t'(SYNC_BITS + 4 * SLOT_BITS - 1);

    cnt_t                 bit_cnt;
    cnt_t                 next_cnt;
    cnt_t                 rx_idx;
    logic                 wrap;
    logic                 cmd_accept;
    logic                 pending;
    logic                 in_flight;
    logic [6:0]           pend_addr;
    logic [15:0]          pend_data;
    logic [6:0]           fl_addr;
    logic [15:0]          fl_data;
    logic [SLOT_BITS-1:0] shadow_l;
    logic [SLOT_BITS-1:0] shadow_r;
    logic [SYNC_BITS-1:0] rx_tag;
    logic [SLOT_BITS-1:0] rx_sl;
    logic [SLOT_BITS-1:0] rx_sr;
    logic                 tag_valid;
    logic [SLOT_BITS-1:0] slot_word;
    cnt_t                 slot_end;
    logic                 tx_bit;

    assign wrap       = (bit_cnt == LAST);
    assign next_cnt   = wrap ? '0 : bit_cnt + cnt_t'(1);
    // The codec launches on the same edge we sample, so the bit seen now is one behind.
    assign rx_idx     = bit_cnt - cnt_t'(1);
    assign cmd_ready  = reset_n & ~pending;
    assign cmd_accept = cmd_valid & cmd_ready;
    assign tag_valid  = rx_tag[SYNC_BITS-1] & rx_tag[SYNC_BITS-4] & rx_tag[SYNC_BITS-5];

    // Outputs are registered, so the bit for the next count is chosen one cycle early.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        slot_word = '0;
        slot_end  = S4_END;
        tx_bit    = 1'b0;
        if (next_cnt <= S1_END) begin
            slot_word = in_flight ? {1'b0, fl_addr, {(SLOT_BITS - 8){1'b0}}} : '0;
            slot_end  = S1_END;
        end else if (next_cnt <= S2_END) begin
            slot_word = in_flight ? {fl_data, {(SLOT_BITS - 16){1'b0}}} : '0;
            slot_end  = S2_END;
        end else if (next_cnt <= S3_END) begin
            slot_word = shadow_l;
            slot_end  = S3_END;
        end else if (next_cnt <= S4_END) begin
            slot_word = shadow_r;
            slot_end  = S4_END;
        end
        if (next_cnt > TAG_END && next_cnt <= S4_END) begin
            tx_bit = slot_word[IDX_W'(slot_end - next_cnt)];
        end
        if (next_cnt <= TAG_END) begin
            tx_bit = (next_cnt == cnt_t'(0)) || (next_cnt == cnt_t'(3)) ||
                     (next_cnt == cnt_t'(4)) ||
                     (in_flight && (next_cnt == cnt_t'(1) || next_cnt == cnt_t'(2)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt     <= LAST;
            sync        <= 1'b0;
            sdata_out   <= 1'b0;
            pending     <= 1'b0;
            in_flight   <= 1'b0;
            shadow_l    <= '0;
            shadow_r    <= '0;
            rx_tag      <= '0;
            rx_sl       <= '0;
            rx_sr       <= '0;
            rx_left     <= '0;
            rx_right    <= '0;
            ready       <= 1'b0;
            codec_ready <= 1'b0;
        end else begin
            bit_cnt   <= next_cnt;
            sync      <= (next_cnt <= TAG_END);
            sdata_out <= tx_bit;
            ready     <= 1'b0;

            if (cmd_accept) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            if (rx_idx <= TAG_END) begin
                rx_tag <= {rx_tag[SYNC_BITS-2:0], sdata_in};
            end
            if (rx_idx > S2_END && rx_idx <= S3_END) begin
                rx_sl <= {rx_sl[SLOT_BITS-2:0], sdata_in};
            end
            if (rx_idx > S3_END && rx_idx <= S4_END) begin
                rx_sr <= {rx_sr[SLOT_BITS-2:0], sdata_in};
            end

            if (wrap) begin
                shadow_l    <= tx_left;
                shadow_r    <= tx_right;
                in_flight   <= pending;
                codec_ready <= rx_tag[SYNC_BITS-1];
                if (tag_valid) begin
                    rx_left  <= rx_sl;
                    rx_right <= rx_sr;
                    ready    <= 1'b1;
                end
            end
        end
    end

    // NOTE: command payload registers carry no reset; they are only observed while in_flight is set.
    always_ff @(posedge clock) begin
        if (cmd_accept) begin
            pend_addr <= cmd_addr;
            pend_data <= cmd_data;
        end
        if (wrap) begin
            fl_addr <= pend_addr;
            fl_data <= pend_data;
        end
    end

endmodule

// File: tb/tb_ac97_link.sv
// Scoreboard bench for ac97_link: directed frames are queued as expectations and a
// negedge monitor reassembles each outgoing frame and each ready pulse to compare them.
module tb_ac97_link;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sync;
    logic        sdata_out;
    logic        sdata_in = 1'b0;
    logic [19:0] tx_left;
    logic [19:0] tx_right;
    logic [19:0] rx_left;
    logic [19:0] rx_right;
    logic        ready;
    logic        codec_ready;
    logic        cmd_valid;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_ready;

    ac97_link dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sync        (sync),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in),
        .tx_left     (tx_left),
        .tx_right    (tx_right),
        .rx_left     (rx_left),
        .rx_right    (rx_right),
        .ready       (ready),
        .codec_ready (codec_ready),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          frame_no;
        logic        infl;
        logic [19:0] s1, s2, s3, s4;
    } frame_exp_t;

    typedef struct {
        int          frame_no;
        logic [19:0] l, r;
    } rx_exp_t;

    frame_exp_t fq[$];
    rx_exp_t    rq[$];

    int total = 0;
    int bad   = 0;

    int           pos        = 0;
    int           cur_frame  = -1;
    int           next_frame = 0;
    bit           in_frame   = 1'b0;
    logic         prev_sync  = 1'b0;
    int           sync_err   = 0;
    logic [255:0] fbits      = '0;
    logic [255:0] cf         = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int f, input logic infl, input logic [19:0] s1,
                              input logic [19:0] s2, input logic [19:0] s3, input logic [19:0] s4);
        frame_exp_t e;
        e.frame_no = f; e.infl = infl; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4;
        fq.push_back(e);
    endtask

    task automatic push_rx(input int f, input logic [19:0] l, input logic [19:0] r);
        rx_exp_t e;
        e.frame_no = f; e.l = l; e.r = r;
        rq.push_back(e);
    endtask

    // Codec frame image, indexed by frame bit; fields go out MSB first.
    task automatic set_codec(input logic [15:0] tag, input logic [19:0] l, input logic [19:0] r);
        logic [255:0] img;
        img = '0;
        for (int i = 0; i < 16; i++) img[i] = tag[15-i];
        for (int i = 0; i < 20; i++) begin
            img[56+i] = l[19-i];
            img[76+i] = r[19-i];
        end
        cf = img;
    endtask

    task automatic finish_frame();
        logic [15:0] tag;
        logic [19:0] s [4];
        logic        tail;
        frame_exp_t  e;
        check($sformatf("f%0d_sync_shape", cur_frame), sync_err, 0);
        for (int i = 0; i < 16; i++) tag[15-i] = fbits[i];
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 20; i++) s[k][19-i] = fbits[16 + 20*k + i];
        tail = |fbits[255:96];
        while (fq.size() > 0 && fq[0].frame_no < cur_frame) begin
            check("frame_missing", fq[0].frame_no, cur_frame);
            void'(fq.pop_front());
        end
        if (fq.size() > 0 && fq[0].frame_no == cur_frame) begin
            e = fq.pop_front();
            check($sformatf("f%0d_tag", cur_frame), tag, {1'b1, e.infl, e.infl, 2'b11, 11'b0});
            check($sformatf("f%0d_slot1", cur_frame), s[0], e.s1);
            check($sformatf("f%0d_slot2", cur_frame), s[1], e.s2);
            check($sformatf("f%0d_slot3", cur_frame), s[2], e.s3);
            check($sformatf("f%0d_slot4", cur_frame), s[3], e.s4);
            check($sformatf("f%0d_tail", cur_frame), tail, 1'b0);
        end
    endtask

    task automatic ready_seen();
        rx_exp_t e;
        if (rq.size() == 0) begin
            check("ready_unexpected", ready, 1'b0);
        end else begin
            e = rq.pop_front();
            check("ready_when", cur_frame * 256 + pos, e.frame_no * 256);
            check("rx_left", rx_left, e.l);
            check("rx_right", rx_right, e.r);
            check("codec_ready_at_ready", codec_ready, 1'b1);
        end
    endtask

    // Monitor: tracks frame position from SYNC, rebuilds frames, scores ready pulses.
    always @(negedge clock) begin
        if (reset_n !== 1'b1) begin
            in_frame  = 1'b0;
            prev_sync = 1'b0;
        end else begin
            if (sync === 1'b1 && prev_sync !== 1'b1) begin
                if (in_frame && pos != 255) check("frame_short", pos + 1, 256);
                in_frame  = 1'b1;
                pos       = 0;
                cur_frame = next_frame;
                next_frame++;
                sync_err  = 0;
            end else if (in_frame) begin
                pos++;
                if (pos > 255) begin
                    check("frame_long", pos, 255);
                    in_frame = 1'b0;
                end
            end
            if (in_frame) begin
                fbits[pos] = sdata_out;
                if (sync !== (pos < 16)) sync_err++;
                if (pos == 255) finish_frame();
            end
            if (ready !== 1'b0) ready_seen();
            prev_sync = sync;
        end
    end

    // Codec model: during count n it presents frame bit n-1.
    always @(negedge clock) begin
        #1;
        sdata_in = (reset_n === 1'b1 && in_frame && pos >= 1) ? cf[pos-1] : 1'b0;
    end

    task automatic wait_pos(input int f, input int p);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(in_frame && cur_frame == f && pos == p) && n < 4000);
        if (n >= 4000) check($sformatf("wait_f%0d_p%0d", f, p), n, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        tx_left   = 20'hA5A5A;
        tx_right  = 20'h0F0F0;
        cmd_valid = 1'b0;
        cmd_addr  = 7'h00;
        cmd_data  = 16'h0000;
        repeat (4) @(negedge clock);
        #1;
        check("rst_sync", sync, 1'b0);
        check("rst_sdata_out", sdata_out, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_codec_ready", codec_ready, 1'b0);
        check("rst_rx_left", rx_left, 20'h0);
        check("rst_rx_right", rx_right, 20'h0);
        check("rst_cmd_ready", cmd_ready, 1'b0);

        push_frame(0, 1'b0, 20'h0, 20'h0, 20'hA5A5A, 20'h0F0F0);
        push_frame(1, 1'b0, 20'h0, 20'h0, 20'hA5A5A, 20'h0F0F0);
        reset_n = 1'b1;

        wait_pos(1, 10);
        tx_left = 20'h11111;
        push_frame(2, 1'b0, 20'h0, 20'h0, 20'h11111, 20'h0F0F0);

        wait_pos(2, 60);
        tx_left = 20'h22222;

        wait_pos(2, 100);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h02;
        cmd_data  = 16'h0808;
        push_frame(3, 1'b1, 20'h02000, 20'h08080, 20'h22222, 20'h0F0F0);
        wait_pos(2, 101);
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", cmd_ready, 1'b0);
        wait_pos(2, 255);
        check("cmd_ready_before_wrap", cmd_ready, 1'b0);
        wait_pos(3, 0);
        check("cmd_ready_after_wrap", cmd_ready, 1'b1);
        push_frame(4, 1'b0, 20'h0, 20'h0, 20'h22222, 20'h0F0F0);

        wait_pos(3, 200);
        set_codec(16'h9800, 20'h12345, 20'hFEDCB);
        push_rx(5, 20'h12345, 20'hFEDCB);

        wait_pos(4, 200);
        set_codec(16'h8800, 20'hABCDE, 20'h13579);

        wait_pos(4, 255);
        check("cmd_ready_at_wrap", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h55;
        cmd_data  = 16'hBEEF;
        push_frame(5, 1'b0, 20'h0, 20'h0, 20'h22222, 20'h0F0F0);
        push_frame(6, 1'b1, 20'h55000, 20'hBEEF0, 20'h22222, 20'h0F0F0);
        wait_pos(5, 0);
        cmd_valid = 1'b0;
        check("cmd_ready_wrap_accept", cmd_ready, 1'b0);

        wait_pos(5, 200);
        set_codec(16'h1800, 20'h11111, 20'h22222);

        wait_pos(6, 0);
        check("cmd_ready_f6", cmd_ready, 1'b1);
        push_frame(7, 1'b0, 20'h0, 20'h0, 20'h22222, 20'h0F0F0);
        wait_pos(6, 5);
        check("hold_rx_left", rx_left, 20'h12345);
        check("hold_rx_right", rx_right, 20'hFEDCB);
        check("hold_codec_ready", codec_ready, 1'b1);

        wait_pos(7, 5);
        check("codec_not_ready", codec_ready, 1'b0);
        check("hold2_rx_left", rx_left, 20'h12345);

        wait_pos(7, 50);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h7F;
        cmd_data  = 16'hFFFF;
        wait_pos(7, 51);
        cmd_valid = 1'b0;
        wait_pos(7, 200);
        set_codec(16'h0000, 20'h0, 20'h0);

        wait_pos(8, 100);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            #1;
        end
        check("mid_rst_sync", sync, 1'b0);
        check("mid_rst_sdata_out", sdata_out, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b0);
        check("mid_rst_codec_ready", codec_ready, 1'b0);
        check("mid_rst_rx_left", rx_left, 20'h0);
        check("mid_rst_rx_right", rx_right, 20'h0);
        check("mid_rst_ready", ready, 1'b0);
        push_frame(9, 1'b0, 20'h0, 20'h0, 20'h22222, 20'h0F0F0);
        push_frame(10, 1'b0, 20'h0, 20'h0, 20'h22222, 20'h0F0F0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("sync_after_release", sync, 1'b1);

        wait_pos(10, 255);
        repeat (2) @(negedge clock);
        check("frame_queue_empty", fq.size(), 0);
        check("rx_queue_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
